// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 MIPS register file, $0 hardwired, jal link write, write counter
// Optional write-first read bypass under `REGFILE_BYPASS_EN.
module reg_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jal,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] d,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] q1,
    output logic [DATA_W-1:0] q2,
    output logic [15:0]       wr_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              we_eff;
    logic [ADDR_W-1:0] wa_eff;
    logic              commit;

    assign we_eff = we | jal;
    assign wa_eff = jal ? LINK_A : wa;
    assign commit = we_eff && (wa_eff != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_cnt <= '0;
        end else if (commit) begin
            mem[wa_eff] <= d;
            wr_cnt      <= wr_cnt + 16'd1;
        end
    end

    // Index 0 is gated here rather than relying on mem[0] staying clear.
    always_comb begin
        q1 = '0;
        q2 = '0;
        if (ra1 != '0) begin
            q1 = mem[ra1];
`ifdef REGFILE_BYPASS_EN
            if (commit && !rst && (ra1 == wa_eff)) q1 = d;
`endif
        end
        if (ra2 != '0) begin
            q2 = mem[ra2];
`ifdef REGFILE_BYPASS_EN
            if (commit && !rst && (ra2 == wa_eff)) q2 = d;
`endif
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file (directed table, random vs model, wrap)
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst, jal, we;
    logic [4:0]  wa, ra1, ra2;
    logic [31:0] d, q1, q2;
    logic [15:0] wr_cnt;

    int n_pass = 0;
    int n_total = 0;

    reg_file dut (
        .clk(clk), .rst(rst), .jal(jal), .we(we), .wa(wa), .d(d),
        .ra1(ra1), .ra2(ra2), .q1(q1), .q2(q2), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        rst, jal, we;
        logic [4:0]  wa;
        logic [31:0] d;
        logic [4:0]  ra1, ra2;
        logic [31:0] q1_nb, q1_b, q2_nb, q2_b;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[10];

    int unsigned model[32];
    int unsigned mcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic r, input logic j, input logic w, input logic [4:0] a,
                         input logic [31:0] dd, input logic [4:0] r1, input logic [4:0] r2);
        rst = r; jal = j; we = w; wa = a; d = dd; ra1 = r1; ra2 = r2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected read value from the architectural state plus the write being presented.
    function automatic logic [31:0] expect_read(input logic [4:0] ra);
        int unsigned dst;
        if (ra == 0) return 32'h0;
        dst = jal ? 31 : int'(wa);
        if (BYP && !rst && (we || jal) && dst != 0 && dst == int'(ra)) return d;
        return model[ra];
    endfunction

    function automatic void model_edge();
        int unsigned dst;
        dst = jal ? 31 : int'(wa);
        if (rst) begin
            foreach (model[i]) model[i] = 0;
            mcnt = 0;
        end else if ((we || jal) && dst != 0) begin
            model[dst] = d;
            mcnt = (mcnt + 1) % 65536;
        end
    endfunction

    initial begin
        //          rst jal we wa  d             ra1 ra2 q1_nb         q1_b          q2_nb         q2_b          cnt
        vecs[0] = '{0, 0, 1, 8,  32'hDEADBEEF, 8,  8,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 16'd0};
        vecs[1] = '{0, 0, 0, 0,  32'h0,        8,  8,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
        vecs[2] = '{0, 0, 1, 0,  32'h12345678, 0,  8,  32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
        vecs[3] = '{0, 1, 0, 5,  32'h00400010, 0,  5,  32'h0,        32'h0,        32'h0,        32'h0,        16'd1};
        vecs[4] = '{0, 0, 0, 0,  32'h0,        31, 5,  32'h00400010, 32'h00400010, 32'h0,        32'h0,        16'd2};
        vecs[5] = '{0, 0, 1, 9,  32'h1,        9,  31, 32'h0,        32'h1,        32'h00400010, 32'h00400010, 16'd2};
        vecs[6] = '{0, 0, 1, 9,  32'h2,        9,  9,  32'h1,        32'h2,        32'h1,        32'h2,        16'd3};
        vecs[7] = '{0, 0, 0, 0,  32'h0,        9,  8,  32'h2,        32'h2,        32'hDEADBEEF, 32'hDEADBEEF, 16'd4};
        vecs[8] = '{1, 0, 1, 3,  32'hFF,       3,  9,  32'h0,        32'h0,        32'h2,        32'h2,        16'd4};
        vecs[9] = '{0, 0, 0, 0,  32'h0,        3,  9,  32'h0,        32'h0,        32'h0,        32'h0,        16'd0};

        drive(1, 0, 1, 7, 32'hA5A5A5A5, 0, 0);
        tick();
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            ra2 = 5'(31 - a);
            #1;
            chk($sformatf("reset_q1[%0d]", a), q1, 32'h0);
            chk($sformatf("reset_q2[%0d]", 31 - a), q2, 32'h0);
        end
        chk("reset_wr_cnt", {16'h0, wr_cnt}, 32'h0);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rst, vecs[i].jal, vecs[i].we, vecs[i].wa, vecs[i].d, vecs[i].ra1, vecs[i].ra2);
            @(negedge clk);
            chk($sformatf("vec%0d_q1", i), q1, BYP ? vecs[i].q1_b : vecs[i].q1_nb);
            chk($sformatf("vec%0d_q2", i), q2, BYP ? vecs[i].q2_b : vecs[i].q2_nb);
            chk($sformatf("vec%0d_wr_cnt", i), {16'h0, wr_cnt}, {16'h0, vecs[i].cnt});
            tick();
        end

        // Hardware is now in reset state; align the model and run random traffic.
        foreach (model[i]) model[i] = 0;
        mcnt = 0;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0), 1'($urandom),
                  5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 2) : $urandom),
                  $urandom, 5'($urandom), 5'($urandom));
            if ($urandom_range(0, 3) == 0) ra1 = jal ? 5'd31 : wa;
            @(negedge clk);
            chk($sformatf("rand%0d_q1", i), q1, expect_read(ra1));
            chk($sformatf("rand%0d_q2", i), q2, expect_read(ra2));
            chk($sformatf("rand%0d_wr_cnt", i), {16'h0, wr_cnt}, mcnt);
            model_edge();
            tick();
        end

        drive(1, 0, 0, 0, 32'h0, 1, 0);
        tick();
        for (int i = 0; i < 65536; i++) begin
            drive(0, 0, 1, 1, 32'(i), 1, 0);
            tick();
            if (i == 65534) chk("wrap_pre_ffff", {16'h0, wr_cnt}, 32'h0000FFFF);
        end
        drive(0, 0, 0, 1, 32'h0, 1, 0);
        #1;
        chk("wrap_wr_cnt", {16'h0, wr_cnt}, 32'h0);
        chk("wrap_last_data", q1, 32'd65535);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
